// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: command bytes,
// FSM encoding, write size and the header count check.
package imem_loader_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_HALT = 8'h48;

   localparam logic [1:0] WSIZE_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_DONE
   } state_t;

   // A count is loadable when it is non-zero and fits in imem.
   function automatic logic count_ok(input logic [15:0] count, input logic [31:0] capacity);
      return (count != 16'd0) && ({16'd0, count} <= capacity);
   endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into a 32-bit word; strobes word_valid the cycle
// after the fourth byte of each word is accepted.
module word_packer
   import imem_loader_pkg::*;
#(
   parameter int NB_WORD = 32
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_byte_valid,
   input  logic [7:0]         i_byte,
   output logic [1:0]         o_byte_idx,
   output logic [NB_WORD-1:0] o_word,
   output logic               o_word_valid
);

   logic [NB_WORD-1:0] shift_q;

   // Bytes enter at the top and move down, so byte 0 ends in bits [7:0].
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_byte_idx   <= 2'd0;
         shift_q      <= '0;
         o_word       <= '0;
         o_word_valid <= 1'b0;
      end else if (i_clear) begin
         o_byte_idx   <= 2'd0;
         shift_q      <= '0;
         o_word_valid <= 1'b0;
      end else begin
         o_word_valid <= 1'b0;
         if (i_byte_valid) begin
            shift_q    <= {i_byte, shift_q[NB_WORD-1:8]};
            o_byte_idx <= o_byte_idx + 2'd1;
            if (o_byte_idx == 2'd3) begin
               o_word       <= {i_byte, shift_q[NB_WORD-1:8]};
               o_word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Debug-UART program loader: decodes L/R/H commands, streams words into imem
// and holds the CPU halted while a program is loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int NB_INSTRUCTION  = 32,
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter int NB_COUNT        = 16
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic [7:0]                 i_rx_data,
   input  logic                       i_rx_valid,
   output logic [NB_INSTRUCTION-1:0]  o_imem_data,
   output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
   output logic [1:0]                 o_mem_wsize,
   output logic                       o_imem_wen,
   output logic                       o_cpu_en,
   output logic                       o_cpu_rst,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   localparam logic [31:0] CAPACITY = 32'((2 ** IMEM_ADDR_WIDTH) / 4);

   state_t              state;
   logic                run_q;
   logic [7:0]          len_lo_q;
   logic [NB_COUNT-1:0] count_q;
   logic [NB_COUNT-1:0] word_cnt;
   logic [1:0]          byte_idx;
   logic                packer_clear;
   logic                packer_valid;
   logic [15:0]         header;

   assign header       = {i_rx_data, len_lo_q};
   assign packer_clear = (state == ST_IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);
   assign packer_valid = (state == ST_DATA) && i_rx_valid;

   word_packer #(
      .NB_WORD (NB_INSTRUCTION)
   ) u_packer (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_clear      (packer_clear),
      .i_byte_valid (packer_valid),
      .i_byte       (i_rx_data),
      .o_byte_idx   (byte_idx),
      .o_word       (o_imem_data),
      .o_word_valid (o_imem_wen)
   );

   assign o_mem_wsize = WSIZE_WORD;
   assign o_cpu_en    = run_q & ~o_busy;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         run_q        <= 1'b0;
         len_lo_q     <= 8'd0;
         count_q      <= '0;
         word_cnt     <= '0;
         o_imem_waddr <= '0;
         o_cpu_rst    <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_cpu_rst <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Busy is held through the o_done cycle and drops here.
               o_busy <= 1'b0;
               if (i_rx_valid) begin
                  case (i_rx_data)
                     CMD_LOAD: begin
                        state  <= ST_LEN_LO;
                        o_busy <= 1'b1;
                        run_q  <= 1'b0;
                     end
                     CMD_RUN:  run_q <= 1'b1;
                     CMD_HALT: run_q <= 1'b0;
                     default: ;
                  endcase
               end
            end
            ST_LEN_LO: begin
               if (i_rx_valid) begin
                  len_lo_q <= i_rx_data;
                  state    <= ST_LEN_HI;
               end
            end
            ST_LEN_HI: begin
               if (i_rx_valid) begin
                  if (count_ok(header, CAPACITY)) begin
                     count_q  <= NB_COUNT'(header);
                     word_cnt <= '0;
                     state    <= ST_DATA;
                  end else begin
                     o_err  <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               // Address is registered alongside the packer's word strobe.
               if (i_rx_valid && (byte_idx == 2'd3)) begin
                  o_imem_waddr <= IMEM_ADDR_WIDTH'({word_cnt, 2'b00});
                  word_cnt     <= word_cnt + NB_COUNT'(1);
                  if (word_cnt == count_q - NB_COUNT'(1)) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               o_done    <= 1'b1;
               o_cpu_rst <= 1'b1;
               run_q     <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the CPU instruction-memory write port. Consumes a byte stream from the debug UART receiver, decodes a small command set, and packs little-endian bytes into 32-bit instruction words. Each word is issued as a single-cycle write with an incrementing address. While a program is loading, the block holds the CPU core halted. It restarts the core from PC 0 when the load completes.

## Interface
Parameters:
- NB_INSTRUCTION, 32, width of instruction word written to imem
- IMEM_ADDR_WIDTH, 8, imem byte-address width; capacity = 2^IMEM_ADDR_WIDTH / 4 words (64 at default)
- NB_COUNT, 16, width of the word-count field in the load header

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe; byte accepted in that cycle, no backpressure
- o_imem_data  out  NB_INSTRUCTION  assembled instruction word
- o_imem_waddr  out  IMEM_ADDR_WIDTH  byte address of word being written
- o_mem_wsize  out  2  write size; constant 2'b10 (word)
- o_imem_wen  out  1  one-cycle write strobe
- o_cpu_en  out  1  CPU core enable
- o_cpu_rst  out  1  one-cycle CPU reset pulse
- o_busy  out  1  high while a load is in progress
- o_done  out  1  one-cycle pulse, load finished
- o_err  out  1  one-cycle pulse, header rejected

## Operation
- Commands, accepted in IDLE only:
  - 0x4C 'L': load.
  - 0x52 'R': set run, so o_cpu_en=1 from the next cycle.
  - 0x48 'H': clear run, so o_cpu_en=0.
  - Any other byte is ignored.
- Load header: two bytes giving the word count N, low byte first.
- If N==0 or N > capacity: pulse o_err and return to IDLE. Address, run flag and memory are untouched.
- Then 4*N data bytes follow. Byte k of a word fills bits [8k+7:8k], little-endian.
- After the 4th byte of a word:
  - o_imem_data is the full word and o_imem_wen pulses.
  - o_imem_waddr equals 4*(word index). The first word is written to 0.
- After word N-1 is written: pulse o_done, pulse o_cpu_rst, set run=1, return to IDLE.
- o_cpu_en = run AND NOT o_busy. The run flag is cleared on entering LEN_LO.
- FSM states and transitions:
  - IDLE → LEN_LO on 'L'.
  - LEN_LO → LEN_HI on a byte.
  - LEN_HI → DATA on a byte with a valid count; LEN_HI → IDLE (with o_err) on an invalid count.
  - DATA → DONE on the last byte of the last word.
  - DONE → IDLE after one cycle.
- Byte index is a 2-bit counter that wraps 3→0. The word counter runs 0..N-1.
- An address of 4*(capacity-1) is the last legal one. Addresses never wrap, because the count check prevents it.
- No timeout. An incomplete load stays in DATA until reset.

## Timing
- Reset values:
  - All outputs 0, except o_mem_wsize=2'b10.
  - Run flag 0, FSM in IDLE, counters 0.
- Byte accepted in cycle t (i_rx_valid=1).
- 4th byte of a word at cycle t → o_imem_wen=1 with valid data/address in t+1, for exactly one cycle.
- Last word: o_imem_wen in t+1; o_done, o_cpu_rst, and run=1 in t+2. o_cpu_en=1 from t+3.
- Invalid header byte at t → o_err in t+1, and the FSM is in IDLE in t+1.
- Bytes may arrive on consecutive cycles. A write strobe in t+1 must not block acceptance of a byte in t+1.
- o_busy=1 from the cycle after 'L' is accepted until the cycle o_done pulses, inclusive.
- i_rst mid-load:
  - FSM returns to IDLE next cycle and all outputs take reset values.
  - A partially assembled word is discarded; already-written words stay in imem.

## Structure
- Shared package:
  - command byte constants CMD_LOAD, CMD_RUN, CMD_HALT
  - FSM state encoding ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DONE
  - WSIZE_WORD = 2'b10
- Sub-module word_packer:
  - byte-index counter plus shift/assemble register
  - outputs the full word and a word_valid strobe
  - clear input driven by the FSM on header entry and on reset

## Test plan
- Load N=2, bytes 13 00 00 00 93 00 10 00 → writes 0x00000013 @0x00 and 0x00100093 @0x04. Then o_done, o_cpu_rst, and o_cpu_en=1 with the timing above.
- 'L' with N=0, then N=65 at default capacity → o_err pulse each time, no o_imem_wen, FSM in IDLE, o_cpu_en stays 0.
- 'R' in IDLE → o_cpu_en=1 next cycle. 'H' → 0. Byte 0x41 in IDLE → no output change.
- Load N=64 with back-to-back bytes on every cycle → 64 writes, last at 0xFC, no dropped bytes, single o_done.
- i_rst asserted after 2 data bytes of word 1 → all outputs at reset values next cycle. A new 'L' N=1 load then writes its first word @0x00.
- 'R' then a load → o_cpu_en drops the cycle after 'L' and returns to 1 only after o_done.
